// File: rtl/fetch_stage_pkg.sv
// Shared opcode constants, reset instruction encoding and FSM state type for the fetch stage.
package fetch_stage_pkg;

  localparam logic [4:0]  OPCODE_System = 5'b11100;
  localparam logic [4:0]  OPCODE_Fence  = 5'b00011;
  localparam logic [31:0] INST_NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_S_FETCH = 2'd0,
    FETCH_S_HOLD  = 2'd1,
    FETCH_S_HALT  = 2'd2
  } fetch_state_e;

  // ECALL/EBREAK/PAUSE/FENCE stop the stage; only inst[6:2] matters.
  function automatic logic is_halt_op(input logic [4:0] opc);
    return (opc == OPCODE_System) || (opc == OPCODE_Fence);
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry buffer parking a fetched word while decode is stalled.
module fetch_hold_buf
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic        i_clear,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_full
);

  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic        r_full;

  // Clear (redirect) beats load so a flushed word never survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inst <= INST_NOP;
      r_pc   <= 32'h0;
      r_full <= 1'b0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_inst <= i_inst;
      r_pc   <= i_pc;
      r_full <= 1'b1;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end

  assign o_inst = r_inst;
  assign o_pc   = r_pc;
  assign o_full = r_full;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem handshake, IF/ID register, stall/redirect/halt handling.
// Optional FETCH_MISALIGN_CHECK_EN adds fetch_err for misaligned redirect targets.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        halted
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_err
`endif
);

  fetch_state_e r_state, w_state_d;
  logic [31:0]  r_pc, w_pc_d;
  logic [31:0]  r_ifid_inst, w_ifid_inst_d;
  logic [31:0]  r_ifid_pc, w_ifid_pc_d;
  logic [31:0]  r_ifid_pc4, w_ifid_pc4_d;
  logic         r_ifid_valid, w_ifid_valid_d;

  logic         w_hs;
  logic         w_halt_op;
  logic [31:0]  w_pc_inc;
  logic [31:0]  w_redirect_tgt;
  logic         w_hb_load, w_hb_drain, w_hb_clear;
  logic [31:0]  w_hb_inst, w_hb_pc;
  logic         w_hb_full;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_fetch_err, w_fetch_err_d;
`else
  logic w_unused_pc_lsb;
  assign w_unused_pc_lsb = ^redirect_pc[1:0];
`endif

  assign w_hs           = (r_state == FETCH_S_FETCH) && imem_valid;
  assign w_halt_op      = is_halt_op(imem_rdata[6:2]);
  assign w_pc_inc       = r_pc + 32'd4;
  assign w_redirect_tgt = {redirect_pc[31:2], 2'b00};

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_hb_load),
    .i_drain (w_hb_drain),
    .i_clear (w_hb_clear),
    .i_inst  (imem_rdata),
    .i_pc    (r_pc),
    .o_inst  (w_hb_inst),
    .o_pc    (w_hb_pc),
    .o_full  (w_hb_full)
  );

  always_comb begin
    w_state_d      = r_state;
    w_pc_d         = r_pc;
    w_ifid_inst_d  = r_ifid_inst;
    w_ifid_pc_d    = r_ifid_pc;
    w_ifid_pc4_d   = r_ifid_pc4;
    w_ifid_valid_d = r_ifid_valid;
    w_hb_load      = 1'b0;
    w_hb_drain     = 1'b0;
    w_hb_clear     = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    w_fetch_err_d  = r_fetch_err;
`endif

    if (redirect) begin
      // Redirect wins over stall and drops any word returned this cycle.
      w_pc_d         = w_redirect_tgt;
      w_ifid_valid_d = 1'b0;
      w_hb_clear     = 1'b1;
      w_state_d      = FETCH_S_FETCH;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        w_fetch_err_d = 1'b1;
        w_state_d     = FETCH_S_HALT;
      end
`endif
    end else begin
      case (r_state)
        FETCH_S_FETCH: begin
          if (w_hs) begin
            w_pc_d = w_pc_inc;
            if (stall) begin
              w_hb_load = 1'b1;
              w_state_d = FETCH_S_HOLD;
            end else begin
              w_ifid_inst_d  = imem_rdata;
              w_ifid_pc_d    = r_pc;
              w_ifid_pc4_d   = w_pc_inc;
              w_ifid_valid_d = 1'b1;
            end
            if (w_halt_op) w_state_d = FETCH_S_HALT;
          end else if (!stall) begin
            w_ifid_valid_d = 1'b0;
          end
        end
        FETCH_S_HOLD, FETCH_S_HALT: begin
          // A halt word parked in the hold buffer still reaches decode before draining.
          if (!stall) begin
            if (w_hb_full) begin
              w_ifid_inst_d  = w_hb_inst;
              w_ifid_pc_d    = w_hb_pc;
              w_ifid_pc4_d   = w_hb_pc + 32'd4;
              w_ifid_valid_d = 1'b1;
              w_hb_drain     = 1'b1;
            end else begin
              w_ifid_valid_d = 1'b0;
            end
            if (r_state == FETCH_S_HOLD) w_state_d = FETCH_S_FETCH;
          end
        end
        default: w_state_d = FETCH_S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= FETCH_S_FETCH;
      r_pc         <= RESET_PC;
      r_ifid_inst  <= INST_NOP;
      r_ifid_pc    <= RESET_PC;
      r_ifid_pc4   <= RESET_PC + 32'd4;
      r_ifid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_pc         <= w_pc_d;
      r_ifid_inst  <= w_ifid_inst_d;
      r_ifid_pc    <= w_ifid_pc_d;
      r_ifid_pc4   <= w_ifid_pc4_d;
      r_ifid_valid <= w_ifid_valid_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_fetch_err <= 1'b0;
    else      r_fetch_err <= w_fetch_err_d;
  end
  assign fetch_err = r_fetch_err;
`endif

  assign imem_req   = (r_state == FETCH_S_FETCH);
  assign imem_addr  = r_pc;
  assign halted     = (r_state == FETCH_S_HALT);
  assign ifid_inst  = r_ifid_inst;
  assign ifid_pc    = r_ifid_pc;
  assign ifid_pc4   = r_ifid_pc4;
  assign ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall, redirect, halt, wait states, reset, wrap.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_err;
`endif

  logic [31:0] ecall_addr;
  int          n_checks;
  int          n_fail;

  fetch_stage #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifid_inst   (ifid_inst),
    .ifid_pc     (ifid_pc),
    .ifid_pc4    (ifid_pc4),
    .ifid_valid  (ifid_valid),
    .halted      (halted)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_err   (fetch_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // addi x1, x0, addr[13:2]: each word encodes its own address.
  function automatic logic [31:0] addi_word(input logic [31:0] a);
    return {a[13:2], 5'd0, 3'b000, 5'd1, 7'b0010011};
  endfunction

  always_comb begin
    imem_rdata = (imem_addr == ecall_addr) ? 32'h0000_0073 : addi_word(imem_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_addr"}, imem_addr, 32'h0);
    check_eq({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    check_eq({tag, "_inst"}, ifid_inst, 32'h0000_0013);
    check_eq({tag, "_pc"}, ifid_pc, 32'h0);
    check_eq({tag, "_pc4"}, ifid_pc4, 32'h4);
    check_eq({tag, "_valid"}, {31'd0, ifid_valid}, 32'd0);
    check_eq({tag, "_halted"}, {31'd0, halted}, 32'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_valid  = 1'b1;
    ecall_addr  = 32'h40;

    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b1;

    // Zero-wait streaming: IF/ID trails the fetch address by one word.
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_eq("stream_addr", imem_addr, 32'(4 * k));
      check_eq("stream_ifid_pc", ifid_pc, 32'(4 * (k - 1)));
      check_eq("stream_inst", ifid_inst, addi_word(32'(4 * (k - 1))));
      check_eq("stream_valid", {31'd0, ifid_valid}, 32'd1);
    end
    check_eq("stream_pc4", ifid_pc4, 32'h10);

    // Stall three cycles while the word at 0x10 is returned.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("hold_req", {31'd0, imem_req}, 32'd0);
      check_eq("hold_ifid_pc", ifid_pc, 32'h0C);
      check_eq("hold_addr", imem_addr, 32'h14);
    end
    stall = 1'b0;
    tick();
    check_eq("unhold_ifid_pc", ifid_pc, 32'h10);
    check_eq("unhold_inst", ifid_inst, addi_word(32'h10));
    check_eq("unhold_pc4", ifid_pc4, 32'h14);
    check_eq("unhold_req", {31'd0, imem_req}, 32'd1);
    check_eq("unhold_addr", imem_addr, 32'h14);
    tick();
    check_eq("after_hold_ifid_pc", ifid_pc, 32'h14);

    // Redirect under stall: flush, no stale word.
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    stall       = 1'b1;
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    check_eq("redir_addr", imem_addr, 32'h200);
    check_eq("redir_valid", {31'd0, ifid_valid}, 32'd0);
    check_eq("redir_req", {31'd0, imem_req}, 32'd1);
    tick();
    check_eq("redir_ifid_pc", ifid_pc, 32'h200);
    check_eq("redir_inst", ifid_inst, addi_word(32'h200));
    check_eq("redir_valid2", {31'd0, ifid_valid}, 32'd1);

    // ECALL at 0x40 halts the stage.
    redirect    = 1'b1;
    redirect_pc = 32'h3C;
    tick();
    redirect = 1'b0;
    tick();
    check_eq("pre_halt_ifid_pc", ifid_pc, 32'h3C);
    check_eq("pre_halt_halted", {31'd0, halted}, 32'd0);
    tick();
    check_eq("halt_halted", {31'd0, halted}, 32'd1);
    check_eq("halt_req", {31'd0, imem_req}, 32'd0);
    check_eq("halt_inst", ifid_inst, 32'h0000_0073);
    check_eq("halt_ifid_pc", ifid_pc, 32'h40);
    check_eq("halt_valid", {31'd0, ifid_valid}, 32'd1);
    tick();
    check_eq("halt_drain_valid", {31'd0, ifid_valid}, 32'd0);
    check_eq("halt_req2", {31'd0, imem_req}, 32'd0);
    check_eq("halt_pc_frozen", imem_addr, 32'h44);
    check_eq("halt_halted2", {31'd0, halted}, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    check_eq("unhalt_halted", {31'd0, halted}, 32'd0);
    check_eq("unhalt_addr", imem_addr, 32'h80);
    check_eq("unhalt_req", {31'd0, imem_req}, 32'd1);
    tick();
    check_eq("unhalt_ifid_pc", ifid_pc, 32'h80);
    check_eq("unhalt_valid", {31'd0, ifid_valid}, 32'd1);

    // Memory wait states at 0x20, then reset mid-wait.
    redirect    = 1'b1;
    redirect_pc = 32'h1C;
    tick();
    redirect = 1'b0;
    tick();
    check_eq("wait_pre_ifid_pc", ifid_pc, 32'h1C);
    imem_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("wait_addr", imem_addr, 32'h20);
      check_eq("wait_req", {31'd0, imem_req}, 32'd1);
      check_eq("wait_bubble", {31'd0, ifid_valid}, 32'd0);
    end
    rst = 1'b0;
    #1;
    check_reset_state("midrst");
    #3;
    rst        = 1'b1;
    imem_valid = 1'b1;

    // PC wrap at the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check_eq("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    check_eq("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
    check_eq("wrap_pc4", ifid_pc4, 32'h0);
    check_eq("wrap_addr", imem_addr, 32'h0);

    // Misaligned redirect target.
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check_eq("misalign_err", {31'd0, fetch_err}, 32'd1);
    check_eq("misalign_halted", {31'd0, halted}, 32'd1);
    check_eq("misalign_req", {31'd0, imem_req}, 32'd0);
`else
    check_eq("misalign_addr", imem_addr, 32'h100);
    check_eq("misalign_halted", {31'd0, halted}, 32'd0);
    check_eq("misalign_req", {31'd0, imem_req}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
